mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control unit for the 32-bit multi-cycle CPU datapath. Sits directly upstream of the ALU: decodes the opcode and funct fields held in the instruction register, sequences each instruction through fetch/decode/execute/memory/write-back states, and drives every datapath enable, mux select and the 3-bit ALU operation code. Consumes the ALU `Zero` flag to resolve `beq`.

## Interface

No parameters.

- `clk`  in  1  system clock, all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `Zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC load enable (includes conditional branch term)
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read strobe
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register load
- `RegDst`  out  1  write register: 0 = rt, 1 = rd
- `MemtoReg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  0 = PC, 1 = A register
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = signext(imm), 11 = signext(imm)<<2
- `ALUctl`  out  3  000 add, 001 sub, 010 addu, 011 and, 100 or, 101 nor
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `state`  out  4  current state encoding (debug)
- `instr_done`  out  1  high in the final cycle of every instruction
- `illegal`  out  1  one-cycle pulse on unsupported op/funct

## Operation

- Supported: R-type (op 000000) with funct add 100000, addu 100001, sub 100010, and 100100, or 100101, nor 100111; `lw` 100011; `sw` 101011; `beq` 000100; `j` 000010.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9. Encodings 10–15 unreachable; if entered, go to FETCH.
- Transitions: FETCH→DECODE; DECODE→MEMADR (lw/sw), EXEC (legal R-type), BRANCH (beq), JUMP (j), FETCH (illegal); MEMADR→MEMRD (lw) / MEMWR (sw); MEMRD→MEMWB; EXEC→RWB; MEMWB, MEMWR, RWB, BRANCH, JUMP→FETCH.
- Outputs are Moore (functions of `state` only) except `PCWrite` in BRANCH, which equals `Zero`. Every unlisted output is 0.
  - FETCH: MemRead, IRWrite, PCWrite = 1; ALUSrcA 0, ALUSrcB 01, ALUctl 010, PCSource 00.
  - DECODE: ALUSrcA 0, ALUSrcB 11, ALUctl 010 (branch target into ALUOut); `illegal` = 1 if op/funct unsupported.
  - MEMADR: ALUSrcA 1, ALUSrcB 10, ALUctl 010.
  - MEMRD: MemRead 1, IorD 1. MEMWB: RegWrite 1, MemtoReg 1, RegDst 0.
  - MEMWR: MemWrite 1, IorD 1.
  - EXEC: ALUSrcA 1, ALUSrcB 00, ALUctl from funct (add 000, sub 001, addu 010, and 011, or 100, nor 101).
  - RWB: RegWrite 1, RegDst 1, MemtoReg 0.
  - BRANCH: ALUSrcA 1, ALUSrcB 00, ALUctl 001, PCSource 01, PCWrite = Zero.
  - JUMP: PCWrite 1, PCSource 10.
- `instr_done` = 1 in MEMWB, MEMWR, RWB, BRANCH, JUMP, and in DECODE when `illegal`.
- `op`/`funct` are sampled combinationally; stable from DECODE onward because IRWrite is asserted only in FETCH.

## Timing

- Reset: on a rising edge with `rst` = 1, state ← FETCH. While `rst` is high, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, `instr_done`, `illegal` are forced 0; other outputs follow FETCH values. First fetch occurs on the first edge after `rst` falls.
- Reset mid-instruction: abandons the instruction at the next edge; no write strobe is asserted during the reset cycle.
- Cycle counts: `lw` 5, `sw` 4, R-type 4, `beq` 3, `j` 3, illegal 2.
- `Zero` is sampled in the BRANCH cycle only; `Zero` in other states has no effect.
- At most one of MemRead/MemWrite, and one of IRWrite/RegWrite, high in any cycle.

## Test plan

- Reset: hold `rst` 2 cycles mid-EXEC → `state` = 0, all write strobes 0 during reset; after release FETCH asserts MemRead=IRWrite=PCWrite=1.
- `lw` (op 100011) → states 0,1,2,3,4; MEMRD has MemRead=IorD=1; MEMWB has RegWrite=MemtoReg=1; `instr_done` only in cycle 5.
- R-type sweep: funct 100000/100010/100001/100100/100101/100111 → ALUctl in EXEC = 000/001/010/011/100/101; RWB RegWrite=RegDst=1.
- `beq` with Zero=1 → BRANCH PCWrite=1, PCSource=01, ALUctl=001; repeat with Zero=0 → PCWrite=0; both return to FETCH after 3 cycles.
- `sw` then `j` back-to-back → 0,1,2,5 with MemWrite=1 only in state 5; then 0,1,9 with PCWrite=1, PCSource=10.
- Illegal op 111111 and R-type funct 000000 → `illegal`=1 and `instr_done`=1 in DECODE, next state FETCH, no write strobes.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/write-back
// and drives all datapath enables, mux selects and the ALU operation code.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUctl,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnNor  = 6'b100111;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAddu = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;
  localparam logic [2:0] AluOr   = 3'b100;
  localparam logic [2:0] AluNor  = 3'b101;

  state_e     state_q, state_d;
  state_e     cur;
  logic       rtype_legal;
  logic       op_legal;
  logic [2:0] funct_ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    rtype_legal = 1'b1;
    funct_ctl   = AluAddu;
    unique case (funct)
      FnAdd:   funct_ctl = AluAdd;
      FnAddu:  funct_ctl = AluAddu;
      FnSub:   funct_ctl = AluSub;
      FnAnd:   funct_ctl = AluAnd;
      FnOr:    funct_ctl = AluOr;
      FnNor:   funct_ctl = AluNor;
      default: rtype_legal = 1'b0;
    endcase
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OpRtype:               op_legal = rtype_legal;
      OpLw, OpSw, OpBeq, OpJ: op_legal = 1'b1;
      default:               op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (!op_legal)                    state_d = StFetch;
        else if (op == OpLw || op == OpSw) state_d = StMemAdr;
        else if (op == OpRtype)            state_d = StExec;
        else if (op == OpBeq)              state_d = StBranch;
        else                               state_d = StJump;
      end
      StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StRwb;
      default:  state_d = StFetch;
    endcase
  end

  // While in reset the datapath sees FETCH selects, but every strobe is held low.
  assign cur = rst ? StFetch : state_q;

  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUctl     = AluAdd;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUctl  = AluAddu;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        ALUctl     = AluAddu;
        illegal    = !op_legal;
        instr_done = !op_legal;
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUctl  = AluAddu;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUctl  = funct_ctl;
      end
      StRwb: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUctl     = AluSub;
        PCSource   = 2'b01;
        PCWrite    = Zero;
        instr_done = 1'b1;
      end
      StJump: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle
// against hand-written per-state output vectors.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, instr_done, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUctl;
  logic [3:0] state;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mc_control_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct     (funct),
    .Zero      (Zero),
    .PCWrite   (PCWrite),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUctl    (ALUctl),
    .PCSource  (PCSource),
    .state     (state),
    .instr_done(instr_done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //  ALUSrcB[1:0],ALUctl[2:0],PCSource[1:0],instr_done,illegal}
  function automatic logic [17:0] mk(input logic pcw, iord, mr, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [2:0] ctl,
                                     input logic [1:0] pcs, input logic done, ill);
    return {pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, ctl, pcs, done, ill};
  endfunction

  logic [17:0] obs_vec;
  assign obs_vec = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUctl, PCSource, instr_done, illegal};

  logic [17:0] v_rst, v_fetch, v_dec, v_dec_ill, v_madr, v_mrd, v_mwb, v_mwr, v_rwb, v_jump;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Settle, compare state and outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] v);
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
    chk({tag, ".outs"}, {14'd0, obs_vec}, {14'd0, v});
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100001, 6'b100100, 6'b100101, 6'b100111};
  logic [2:0] ctl_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

  initial begin
    v_rst     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0);
    v_fetch   = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0);
    v_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0);
    v_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1, 1);
    v_madr    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
    v_mrd     = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    v_mwb     = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 1, 0);
    v_mwr     = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1, 0);
    v_rwb     = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 1, 0);
    v_jump    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0);

    rst = 1'b1; op = 6'd0; funct = 6'd0; Zero = 1'b0;
    @(posedge clk); #1;
    cyc("reset_hold", 4'd0, v_rst);
    rst = 1'b0;

    // lw
    op = 6'b100011;
    cyc("lw.fetch", 4'd0, v_fetch);
    cyc("lw.decode", 4'd1, v_dec);
    cyc("lw.memadr", 4'd2, v_madr);
    cyc("lw.memrd", 4'd3, v_mrd);
    cyc("lw.memwb", 4'd4, v_mwb);

    // R-type sweep
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      cyc("r.fetch", 4'd0, v_fetch);
      cyc("r.decode", 4'd1, v_dec);
      cyc($sformatf("r.exec%0d", i), 4'd6,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ctl_tab[i], 2'b00, 0, 0));
      cyc("r.rwb", 4'd7, v_rwb);
    end

    // beq taken, then not taken with Zero high outside BRANCH
    op = 6'b000100; funct = 6'd0; Zero = 1'b1;
    cyc("beq1.fetch", 4'd0, v_fetch);
    cyc("beq1.decode", 4'd1, v_dec);
    cyc("beq1.branch", 4'd8, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1, 0));
    cyc("beq0.fetch", 4'd0, v_fetch);
    cyc("beq0.decode", 4'd1, v_dec);
    Zero = 1'b0;
    cyc("beq0.branch", 4'd8, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1, 0));

    // sw then j
    op = 6'b101011;
    cyc("sw.fetch", 4'd0, v_fetch);
    cyc("sw.decode", 4'd1, v_dec);
    cyc("sw.memadr", 4'd2, v_madr);
    cyc("sw.memwr", 4'd5, v_mwr);
    op = 6'b000010;
    cyc("j.fetch", 4'd0, v_fetch);
    cyc("j.decode", 4'd1, v_dec);
    cyc("j.jump", 4'd9, v_jump);

    // illegal op, then illegal R-type funct
    op = 6'b111111;
    cyc("illop.fetch", 4'd0, v_fetch);
    cyc("illop.decode", 4'd1, v_dec_ill);
    op = 6'b000000; funct = 6'b000000;
    cyc("illfn.fetch", 4'd0, v_fetch);
    cyc("illfn.decode", 4'd1, v_dec_ill);

    // reset mid-EXEC held for two cycles
    funct = 6'b100000;
    cyc("rst.fetch", 4'd0, v_fetch);
    cyc("rst.decode", 4'd1, v_dec);
    rst = 1'b1;
    cyc("rst.in_exec", 4'd6, v_rst);
    cyc("rst.held", 4'd0, v_rst);
    rst = 1'b0;
    cyc("rst.refetch", 4'd0, v_fetch);
    cyc("rst.redecode", 4'd1, v_dec);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
